// File: rtl/task_6_pkg.sv
// task_6 shared types: input FSM states, packet size type, defaults.
// Exports DATA_WIDTH_DEFAULT, size_t, task_input_enum and len_ok().
package task_6_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int SIZE_W = 12;

  typedef logic [SIZE_W-1:0] size_t;

  localparam size_t SIZE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DRAIN,
    S_FLUSH
  } task_input_enum;

  function automatic logic len_ok(
    input size_t cnt,
    input size_t size,
    input logic  ovf,
    input size_t depth
  );
    return (cnt == size) && (size != '0) &&
           (size <= depth) && !ovf;
  endfunction

endpackage

// File: rtl/task_6_in_fifo.sv
// Register-based show-ahead FIFO: i_wr_en/i_wr_data in, o_head/o_head_next out,
// i_rd_en pops, i_clr empties; o_full/o_empty/o_count report occupancy.
module task_6_in_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_wr_en,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic                      i_rd_en,
  output logic [DATA_WIDTH-1:0]     o_head,
  output logic [DATA_WIDTH-1:0]     o_head_next,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         rd_idx_next;
  logic                  do_wr, do_rd;

  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_count = wr_ptr_q - rd_ptr_q;

  // A write wins over a pop in the same cycle.
  assign do_wr = i_wr_en && !o_full;
  assign do_rd = i_rd_en && !o_empty && !i_wr_en;

  assign rd_idx_next = rd_ptr_q[AW-1:0] + AW'(1);
  assign o_head      = mem_q[rd_ptr_q[AW-1:0]];
  assign o_head_next = mem_q[rd_idx_next];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr && !i_clr)
      mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
  end

  a_no_wr_rd: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_wr_en && i_rd_en)
  );

endmodule

// File: rtl/task_6_in.sv
// Packet input stage: collects manager beats, length-checks, drains to core.
// Manager side i_tmanager_valid/i_tdata/i_tdata_last; core side o_data/o_data_valid.
module task_6_in
  import task_6_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tmanager_valid,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tdata_last,
  input  size_t                 i_packet_size_in_bytes,
  output logic                  o_tmanager_ready,
  input  logic                  i_core_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_input_last,
  output logic                  o_busy,
  output logic                  o_err_len
);

  localparam int    AW       = $clog2(DEPTH);
  localparam size_t DEPTH_SZ = size_t'(DEPTH);

  task_input_enum        state_q, state_d;
  size_t                 size_q, size_d;
  size_t                 cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  chk_len;
  logic                  wr_en, rd_en, clr;
  logic [DATA_WIDTH-1:0] fifo_head, fifo_head_next;
  logic                  fifo_full, fifo_empty;
  logic [AW:0]           fifo_count;

  assign o_tmanager_ready = (state_q == S_IDLE) ||
                            (state_q == S_RECV);
  assign accept       = i_tmanager_valid && o_tmanager_ready;
  assign o_busy       = (state_q != S_IDLE);
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_input_last = last_q;
  assign o_err_len    = err_q;

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr     = 1'b0;
    chk_len = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d  = i_packet_size_in_bytes;
          cnt_d   = size_t'(1);
          ovf_d   = 1'b0;
          wr_en   = 1'b1;
          state_d = S_RECV;
          chk_len = i_tdata_last;
        end
      end
      S_RECV: begin
        if (accept) begin
          wr_en   = !fifo_full;
          ovf_d   = ovf_q | fifo_full;
          cnt_d   = (cnt_q == SIZE_MAX) ? cnt_q
                  : cnt_q + size_t'(1);
          chk_len = i_tdata_last;
        end
      end
      S_DRAIN: begin
        rd_en = valid_q && i_core_ready;
        if (rd_en) begin
          if (fifo_count == (AW+1)'(1)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            data_d  = fifo_head_next;
            last_d  = (fifo_count == (AW+1)'(2));
          end
        end
      end
      S_FLUSH: begin
        clr     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The first word is registered on the same edge the last beat
    // is accepted; a single-beat packet has not reached the buffer
    // yet, so its word comes straight from i_tdata.
    if (chk_len) begin
      if (len_ok(cnt_d, size_d, ovf_d, DEPTH_SZ)) begin
        state_d = S_DRAIN;
        valid_d = 1'b1;
        last_d  = (size_d == size_t'(1));
        data_d  = (state_q == S_IDLE) ? i_tdata : fifo_head;
      end else begin
        state_d = S_FLUSH;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  task_6_in_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (clr),
    .i_wr_en     (wr_en),
    .i_wr_data   (i_tdata),
    .i_rd_en     (rd_en),
    .o_head      (fifo_head),
    .o_head_next (fifo_head_next),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

endmodule

// File: tb/tb_task_6_in.sv
// Directed bench for task_6_in: vector table plus multi-cycle sequences.
// DATA_WIDTH=8, DEPTH=16.
module tb_task_6_in;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [11:0] m_size;
  logic        m_ready;
  logic        c_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_busy;
  logic        o_err;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  task_6_in #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_tmanager_valid       (m_valid),
    .i_tdata                (m_data),
    .i_tdata_last           (m_last),
    .i_packet_size_in_bytes (m_size),
    .o_tmanager_ready       (m_ready),
    .i_core_ready           (c_ready),
    .o_data                 (o_data),
    .o_data_valid           (o_valid),
    .o_input_last           (o_last),
    .o_busy                 (o_busy),
    .o_err_len              (o_err)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic [11:0] sz;
    logic        cr;
    logic        er, ev;
    logic [7:0]  ed;
    logic        el, eb, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    int v, int d, int l, int sz, int cr,
    int er, int ev, int ed, int el, int eb, int ee
  );
    vec_t t;
    t.v  = 1'(v);  t.d  = 8'(d);  t.l  = 1'(l);
    t.sz = 12'(sz); t.cr = 1'(cr);
    t.er = 1'(er); t.ev = 1'(ev); t.ed = 8'(ed);
    t.el = 1'(el); t.eb = 1'(eb); t.ee = 1'(ee);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int v, int d, int l, int sz, int cr);
    m_valid = 1'(v);
    m_data  = 8'(d);
    m_last  = 1'(l);
    m_size  = 12'(sz);
    c_ready = 1'(cr);
  endtask

  task automatic chk(string nm, int er, int ev, int ed,
                     int el, int eb, int ee);
    logic [12:0] a, e;
    a = {m_ready, o_valid, (ev != 0) ? o_data : 8'h00,
         o_last, o_busy, o_err};
    e = {1'(er), 1'(ev), (ev != 0) ? 8'(ed) : 8'h00,
         1'(el), 1'(eb), 1'(ee)};
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got rdy=%b vld=%b dat=%h lst=%b bsy=%b err=%b want rdy=%b vld=%b dat=%h lst=%b bsy=%b err=%b",
               nm, a[12], a[11], a[10:3], a[2], a[1], a[0],
               e[12], e[11], e[10:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic chk_bit(string nm, logic act, logic exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_data0(string nm);
    nvec++;
    if (o_data !== 8'h00) begin
      nbad++;
      $display("FAIL %s: o_data got %h want 00", nm, o_data);
    end
  endtask

  initial begin
    // 5-beat packet, core always ready; size given on beat 1 only
    tbl.push_back(mk(1,'h11,0,5,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h12,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h13,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h14,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h15,1,0,1,   0,1,'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h12,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h13,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h14,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h15,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,      1,0,0,0,0,0));
    // same packet, core stalls every other cycle
    tbl.push_back(mk(1,'h11,0,5,0,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h12,0,'hfff,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,'h13,0,'hfff,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,'h14,0,'hfff,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,'h15,1,'hfff,0, 0,1,'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,1,'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h12,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,1,'h12,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h13,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,1,'h13,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h14,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,1,'h14,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h15,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,1,'h15,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,      1,0,0,0,0,0));
    // size=4 but 5 beats: flush, then a good 3-beat packet
    tbl.push_back(mk(1,'h21,0,4,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h22,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h23,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h24,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h25,1,0,1,   0,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,1,      1,0,0,0,0,0));
    tbl.push_back(mk(1,'h31,0,3,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h32,0,0,1,   1,0,0,0,1,0));
    tbl.push_back(mk(1,'h33,1,0,1,   0,1,'h31,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h32,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,      0,1,'h33,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,      1,0,0,0,0,0));
    // size=0 single beat is rejected
    tbl.push_back(mk(1,'haa,1,0,0,   0,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,      1,0,0,0,0,0));
    // single-beat packet; valid held high during drain is ignored
    tbl.push_back(mk(1,'h5a,1,1,0,   0,1,'h5a,1,1,0));
    tbl.push_back(mk(1,'h66,1,1,0,   0,1,'h5a,1,1,0));
    tbl.push_back(mk(1,'h66,1,1,1,   1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,      1,0,0,0,0,0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("reset_async", 1, 0, 0, 0, 0, 0);
    chk_data0("reset_data");
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_release", 1, 0, 0, 0, 0, 0);
    chk_data0("reset_release_data");

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l,
            tbl[i].sz, tbl[i].cr);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev,
          tbl[i].ed, tbl[i].el, tbl[i].eb, tbl[i].ee);
    end

    // 20 beats, size=20: overflow and reject
    for (int i = 0; i < 20; i++) begin
      drive(1, 'h70 + i, (i == 19) ? 1 : 0, 20, 0);
      tick();
      if (i < 19)
        chk($sformatf("ovf_recv%0d", i), 1, 0, 0, 0, 1, 0);
    end
    chk("ovf_flush", 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("ovf_idle", 1, 0, 0, 0, 0, 0);
    chk_bit("ovf_fifo_empty", dut.fifo_empty, 1'b1);
    drive(1, 'h41, 0, 2, 1);
    tick();
    drive(1, 'h42, 1, 0, 1);
    tick();
    chk("ovf_next0", 0, 1, 'h41, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    tick();
    chk("ovf_next1", 0, 1, 'h42, 1, 1, 0);
    tick();
    chk("ovf_next_idle", 1, 0, 0, 0, 0, 0);

    // exactly DEPTH beats is a good packet
    for (int i = 0; i < 16; i++) begin
      drive(1, 'h80 + i, (i == 15) ? 1 : 0, 16, 0);
      tick();
    end
    chk("full_first", 0, 1, 'h80, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 1);
      tick();
      if (i < 15)
        chk($sformatf("full_pop%0d", i), 0, 1, 'h81 + i,
            (i == 14) ? 1 : 0, 1, 0);
      else
        chk("full_idle", 1, 0, 0, 0, 0, 0);
    end

    // reset mid-packet after beat 3 of 5
    for (int i = 0; i < 3; i++) begin
      drive(1, 'h51 + i, 0, 5, 1);
      tick();
    end
    chk("mid_recv", 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 1, 0, 0, 0, 0, 0);
    chk_data0("mid_rst_data");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_release", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 'h61 + i, (i == 4) ? 1 : 0, 5, 1);
      tick();
    end
    chk("post_rst0", 0, 1, 'h61, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d", i), 0, 1, 'h61 + i,
          (i == 4) ? 1 : 0, 1, 0);
    end
    tick();
    chk("post_rst_idle", 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/task_6_in.md
TASK_6_IN -- requirements
Module: task_6_in

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width in bits of one manager beat and one core word.
REQ-002 Parameter DEPTH, default 16: buffer capacity in words; must be a power of two.
REQ-003 i_clk  in  1  single clock; all logic is on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_tmanager_valid  in  1  manager beat valid.
REQ-006 i_tdata  in  DATA_WIDTH  manager beat data.
REQ-007 i_tdata_last  in  1  marks the final beat of a packet.
REQ-008 i_packet_size_in_bytes  in  12  declared packet length; sampled on the first beat only.
REQ-009 o_tmanager_ready  out  1  block accepts a beat.
REQ-010 i_core_ready  in  1  task core accepts a word.
REQ-011 o_data  out  DATA_WIDTH  word to the core.
REQ-012 o_data_valid  out  1  o_data is valid.
REQ-013 o_input_last  out  1  o_data is the final word of the packet.
REQ-014 o_busy  out  1  high whenever the state is not S_IDLE.
REQ-015 o_err_len  out  1  one-cycle pulse when a packet is rejected.

Function
REQ-016 The block SHALL implement four states: S_IDLE, S_RECV, S_DRAIN, S_FLUSH.
REQ-017 A beat is accepted only when i_tmanager_valid and o_tmanager_ready are both high.
REQ-018 o_tmanager_ready SHALL be high in S_IDLE and S_RECV, and low in S_DRAIN and S_FLUSH.
REQ-019 S_IDLE, on an accepted beat: latch the size, write the beat to the buffer, set the beat counter to 1, and go to S_RECV; if that beat also carries last, go directly to the length check (REQ-021).
REQ-020 S_RECV, on an accepted beat: write the beat if the buffer is not full, otherwise drop it and set a sticky overflow flag; increment the 12-bit beat counter, saturating at 4095.
REQ-021 Length check, on the accepted last beat: the packet is good when count == latched size, size != 0, size <= DEPTH, and overflow == 0. Good -> S_DRAIN; bad -> S_FLUSH.
REQ-022 S_DRAIN, buffer output: show-ahead. o_data_valid is registered and first rises in the first S_DRAIN cycle; it stays high while the buffer is not empty.
REQ-023 S_DRAIN, pop rule: a word pops when o_data_valid and i_core_ready are both high. While i_core_ready is low, o_data, o_data_valid and o_input_last SHALL hold stable.
REQ-024 S_DRAIN, last word: o_input_last is high exactly when the buffer holds one word; the pop of that word returns the state to S_IDLE.
REQ-025 S_FLUSH lasts one cycle: clear the buffer pointers, pulse o_err_len, return to S_IDLE. No word is presented to the core.
REQ-026 When a write and a pop are both requested in the same cycle, the pop is ignored; this cannot occur by construction and an assertion SHALL check it.
REQ-027 Buffer pointers are log2(DEPTH)+1 bits; they wrap modulo 2*DEPTH for full/empty detection.
REQ-028 Throughput: one beat per cycle in, one word per cycle out. Bubble: one cycle between the last beat and the first o_data_valid.

Reset
REQ-029 Asserting i_rst_n low at any time, including mid-packet, SHALL asynchronously force:
- state to S_IDLE;
- buffer pointers, beat counter, overflow flag and latched size to 0;
- o_data_valid, o_input_last, o_busy and o_err_len to 0;
- o_data to 0.
REQ-030 After reset release, o_tmanager_ready SHALL be 1 from the first clock edge.

Structure
REQ-031 A shared package task_6_pkg SHALL hold the state enum task_input_enum, the 12-bit size type, and DATA_WIDTH_DEFAULT.
REQ-032 The buffer SHALL be a separate sub-module, task_6_in_fifo: synchronous, show-ahead, register-based, with no vendor IP.
REQ-033 Target size for task_6_in plus task_6_in_fifo: 120-400 lines of RTL.

Verification
REQ-034 5-beat packet (0x11..0x15), size=5, i_core_ready=1 -> core sees 0x11..0x15 on consecutive cycles, o_input_last with 0x15, o_err_len never set.
REQ-035 Same packet with i_core_ready toggling 1,0,1,0 -> order preserved, outputs stable while stalled, state returns to S_IDLE after the 5th pop.
REQ-036 Size=4 but 5 beats sent -> o_err_len pulses for one cycle, no o_data_valid, next good packet is delivered intact.
REQ-037 20 beats with size=20 (DEPTH=16) -> overflow, o_err_len pulse, buffer empty afterwards.
REQ-038 i_rst_n pulsed low after beat 3 of 5 -> outputs are 0 immediately, o_tmanager_ready=1 after release, next packet is correct.
REQ-039 Single-beat packet, size=1, first beat carries last -> one word is presented with o_input_last=1; i_tmanager_valid held high during S_DRAIN is ignored.
